// File: rtl/econet_pkg.sv
// Shared constants for the Econet transmit scheduler: register indices, status bits,
// FSM encoding and descriptor layout helpers.
package econet_pkg;

  localparam logic [1:0] TX_REG_START   = 2'd0;
  localparam logic [1:0] TX_REG_END     = 2'd1;
  localparam logic [1:0] TX_REG_CONTROL = 2'd2;

  localparam logic [1:0] SCH_REG_STAGE_START = 2'd0;
  localparam logic [1:0] SCH_REG_PUSH_END    = 2'd1;
  localparam logic [1:0] SCH_REG_CTRL        = 2'd2;
  localparam logic [1:0] SCH_REG_TIMEOUT     = 2'd3;

  localparam int TURN_BIT = 0;
  localparam int BUSY_BIT = 1;
  localparam int XMIT_BIT = 2;

  localparam int CTRL_TURN_BIT   = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int DESC_TURN_W = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_START  = 3'd1,
    ST_WR_CTRL   = 3'd2,
    ST_WR_END    = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_RETIRE    = 3'd6
  } sched_state_e;

  // Descriptor is packed as {start, end, turnaround}.
  function automatic int desc_width(input int cntwidth);
    return 2 * cntwidth + DESC_TURN_W;
  endfunction

endpackage

// File: rtl/econet_tx_scheduler_if.sv
// Simple word-addressed register bus, used both for the CPU side and the transmitter side.
interface econet_tx_scheduler_if;
  logic        select;
  logic [3:0]  we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output select, we, addr, wdata, input rdata);
  modport slave  (input select, we, addr, wdata, output rdata);
endinterface

// File: rtl/econet_desc_fifo.sv
// Circular descriptor queue with full/empty/count; pushes while full are ignored
// and pops while empty are ignored.
module econet_desc_fifo #(
  parameter int QDEPTH = 4,
  parameter int WIDTH  = 19,
  localparam int AW    = $clog2(QDEPTH)
) (
  input  logic             sys_clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int PW = AW + 2;

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0]    diff;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [QDEPTH];
  logic [WIDTH-1:0] mem_d [QDEPTH];

  always_comb begin
    diff    = wr_q - rd_q;
    count   = diff[AW:0];
    empty   = (diff == '0);
    full    = (diff == PW'(QDEPTH));
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = push_data;
    head    = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/econet_tx_scheduler.sv
// Queues CPU-supplied frame descriptors and programs the buffered Econet transmitter
// with one descriptor at a time, retiring each once the transmitter goes idle again.
module econet_tx_scheduler import econet_pkg::*; #(
  parameter int          QDEPTH      = 4,
  parameter int          CNTWIDTH    = 9,
  parameter logic [31:0] TMO_DEFAULT = 32'h00FF_FFFF
) (
  input  logic                  sys_clk,
  input  logic                  resetn,
  econet_tx_scheduler_if.slave  cpu,
  econet_tx_scheduler_if.master tx,
  output logic                  irq
);

  localparam int DW = desc_width(CNTWIDTH);
  localparam int AW = $clog2(QDEPTH);

  logic [CNTWIDTH-1:0] staged_start_q, staged_start_d;
  logic                staged_turn_q, staged_turn_d;
  logic [7:0]          done_cnt_q, done_cnt_d;
  logic                ovf_q, ovf_d, tmo_q, tmo_d;
  logic                irq_en_q, irq_en_d;
  logic [31:0]         timeout_q, timeout_d;
  logic                irq_q, irq_d;
  logic                busy_meta_q, busy_s_q;

  sched_state_e        state_q;
  logic                tx_select_q;
  logic [3:0]          tx_we_q;
  logic [1:0]          tx_addr_q;
  logic [31:0]         tx_wdata_q;
  logic [31:0]         tmo_ctr_q;

  logic                cpu_wr, wr_stage, wr_push, wr_ctrl, wr_tmo;
  logic                clr, retire, tmo_hit, push_drop;
  logic [DW-1:0]       fifo_head;
  logic                fifo_full, fifo_empty;
  logic [AW:0]         fifo_count;
  logic [CNTWIDTH-1:0] head_start, head_end;
  logic                head_turn;
  logic [31:0]         rdata;
  logic                unused_tx_status;

  always_comb begin
    cpu_wr     = cpu.select && (cpu.we != 4'h0);
    wr_stage   = cpu_wr && (cpu.addr == SCH_REG_STAGE_START);
    wr_push    = cpu_wr && (cpu.addr == SCH_REG_PUSH_END);
    wr_ctrl    = cpu_wr && (cpu.addr == SCH_REG_CTRL);
    wr_tmo     = cpu_wr && (cpu.addr == SCH_REG_TIMEOUT);
    clr        = wr_ctrl && cpu.wdata[CTRL_CLEAR_BIT];
    retire     = (state_q == ST_RETIRE);
    push_drop  = wr_push && fifo_full;
    // A timeout of zero never expires; the counter only flags on the 1 -> 0 step.
    tmo_hit    = (state_q == ST_WAIT_BUSY) && !busy_s_q && (tmo_ctr_q == 32'd1);
    head_start = fifo_head[DW-1 -: CNTWIDTH];
    head_end   = fifo_head[CNTWIDTH -: CNTWIDTH];
    head_turn  = fifo_head[0];
  end

  econet_desc_fifo #(
    .QDEPTH (QDEPTH),
    .WIDTH  (DW)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .resetn    (resetn),
    .push      (wr_push),
    .push_data ({staged_start_q, cpu.wdata[CNTWIDTH-1:0], staged_turn_q}),
    .pop       (retire),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A clear on the same cycle as a retire wins, so that retire is not counted.
  always_comb begin
    staged_start_d = wr_stage ? cpu.wdata[CNTWIDTH-1:0] : staged_start_q;
    staged_turn_d  = wr_ctrl ? cpu.wdata[CTRL_TURN_BIT] : staged_turn_q;
    irq_en_d       = wr_ctrl ? cpu.wdata[CTRL_IRQ_EN_BIT] : irq_en_q;
    timeout_d      = wr_tmo ? cpu.wdata : timeout_q;
    if (clr) begin
      done_cnt_d = 8'd0;
      ovf_d      = 1'b0;
      tmo_d      = 1'b0;
    end else begin
      done_cnt_d = done_cnt_q + 8'(retire);
      ovf_d      = ovf_q | push_drop;
      tmo_d      = tmo_q | tmo_hit;
    end
    irq_d = irq_en_d & ((done_cnt_d != 8'd0) | ovf_d | tmo_d);
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      staged_start_q <= '0;
      staged_turn_q  <= 1'b0;
      irq_en_q       <= 1'b0;
      timeout_q      <= TMO_DEFAULT;
      done_cnt_q     <= 8'd0;
      ovf_q          <= 1'b0;
      tmo_q          <= 1'b0;
      irq_q          <= 1'b0;
      busy_meta_q    <= 1'b0;
      busy_s_q       <= 1'b0;
    end else begin
      staged_start_q <= staged_start_d;
      staged_turn_q  <= staged_turn_d;
      irq_en_q       <= irq_en_d;
      timeout_q      <= timeout_d;
      done_cnt_q     <= done_cnt_d;
      ovf_q          <= ovf_d;
      tmo_q          <= tmo_d;
      irq_q          <= irq_d;
      busy_meta_q    <= tx.rdata[BUSY_BIT];
      busy_s_q       <= busy_meta_q;
    end
  end

  // Outputs are registered with the state, so each state's bus cycle is set up on entry.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      tx_select_q <= 1'b0;
      tx_we_q     <= 4'h0;
      tx_addr_q   <= TX_REG_CONTROL;
      tx_wdata_q  <= 32'd0;
      tmo_ctr_q   <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q     <= ST_WR_START;
            tx_select_q <= 1'b1;
            tx_we_q     <= 4'hF;
            tx_addr_q   <= TX_REG_START;
            tx_wdata_q  <= 32'(head_start);
          end
        end
        ST_WR_START: begin
          state_q    <= ST_WR_CTRL;
          tx_addr_q  <= TX_REG_CONTROL;
          tx_wdata_q <= 32'(head_turn);
        end
        ST_WR_CTRL: begin
          state_q    <= ST_WR_END;
          tx_addr_q  <= TX_REG_END;
          tx_wdata_q <= 32'(head_end);
        end
        ST_WR_END: begin
          state_q    <= ST_WAIT_BUSY;
          tx_we_q    <= 4'h0;
          tx_addr_q  <= TX_REG_CONTROL;
          tx_wdata_q <= 32'd0;
          tmo_ctr_q  <= timeout_q;
        end
        ST_WAIT_BUSY: begin
          if (busy_s_q) state_q <= ST_WAIT_DONE;
          else if (tmo_ctr_q != 32'd0) tmo_ctr_q <= tmo_ctr_q - 32'd1;
        end
        ST_WAIT_DONE: begin
          if (!busy_s_q) begin
            state_q     <= ST_RETIRE;
            tx_select_q <= 1'b0;
          end
        end
        ST_RETIRE: state_q <= ST_IDLE;
        default: begin
          state_q     <= ST_IDLE;
          tx_select_q <= 1'b0;
          tx_we_q     <= 4'h0;
          tx_addr_q   <= TX_REG_CONTROL;
          tx_wdata_q  <= 32'd0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (cpu.addr)
      SCH_REG_STAGE_START: rdata[CNTWIDTH-1:0] = staged_start_q;
      SCH_REG_PUSH_END:    rdata[AW+2:0] = {fifo_count, fifo_full, fifo_empty};
      SCH_REG_CTRL: begin
        rdata[31:24] = done_cnt_q;
        rdata[10:8]  = state_q;
        rdata[5]     = tmo_q;
        rdata[4]     = ovf_q;
        rdata[2]     = irq_en_q;
        rdata[0]     = staged_turn_q;
      end
      default:             rdata = timeout_q;
    endcase
  end

  assign cpu.rdata        = rdata;
  assign tx.select        = tx_select_q;
  assign tx.we            = tx_we_q;
  assign tx.addr          = tx_addr_q;
  assign tx.wdata         = tx_wdata_q;
  assign irq              = irq_q;
  assign unused_tx_status = ^{tx.rdata[31:XMIT_BIT], tx.rdata[TURN_BIT]};

endmodule
